// File: rtl/resp_stream_ctrl.sv
// Response FIFO to UART framer: header, big-endian word count, then each FIFO word MSB first.
// Define RESP_STREAM_CHECKSUM_EN to append an XOR checksum byte (count + payload bytes).
module resp_stream_ctrl #(
    parameter int                    RESPONSE_BITS = 32,
    parameter int                    DATA_BITS     = 8,
    parameter int                    COUNT_BITS    = 16,
    parameter logic [DATA_BITS-1:0]  RESPONSE_ID   = 8'b10101011
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     abort,
    input  logic [COUNT_BITS-1:0]    word_count,
    input  logic                     fifo_empty,
    input  logic [RESPONSE_BITS-1:0] fifo_dout,
    output logic                     fifo_rd_en,
    input  logic                     tx_busy,
    output logic                     tx_enable,
    output logic [DATA_BITS-1:0]     tx_data,
    output logic                     busy,
    output logic                     done,
    output logic                     stall
);
    localparam int CNT_BYTES  = COUNT_BITS / DATA_BITS;
    localparam int WORD_BYTES = RESPONSE_BITS / DATA_BITS;
    localparam int IDX_W      = 8;
    localparam logic [IDX_W-1:0] CNT_LAST  = IDX_W'(CNT_BYTES - 1);
    localparam logic [IDX_W-1:0] WORD_LAST = IDX_W'(WORD_BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_CNT, S_FETCH, S_LATCH, S_SEND,
`ifdef RESP_STREAM_CHECKSUM_EN
        S_CSUM,
`endif
        S_DONE
    } state_t;

    // Per-byte handshake: wait for idle UART, wait for ACK (busy high), wait for busy low.
    typedef enum logic [1:0] { PH_FREE, PH_ACK, PH_END } phase_t;

    state_t                   state_q, state_d;
    phase_t                   ph_q, ph_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [COUNT_BITS-1:0]    words_q, words_d;
    logic [COUNT_BITS-1:0]    count_q, count_d;
    logic [RESPONSE_BITS-1:0] shreg_q, shreg_d;
    logic                     tx_en_q, tx_en_d;
    logic [DATA_BITS-1:0]     tx_data_q, tx_data_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
`ifdef RESP_STREAM_CHECKSUM_EN
    logic [DATA_BITS-1:0]     csum_q, csum_d;
`endif

    logic                     iss, field_end, finish;
    state_t                   iss_state;
    logic [IDX_W-1:0]         iss_idx;
    logic [RESPONSE_BITS-1:0] iss_word;
    logic [DATA_BITS-1:0]     iss_byte;

    function automatic logic [DATA_BITS-1:0] word_byte(input logic [RESPONSE_BITS-1:0] w,
                                                       input logic [IDX_W-1:0] i);
        logic [RESPONSE_BITS-1:0] s;
        s = w << (i * DATA_BITS);
        return s[RESPONSE_BITS-1 -: DATA_BITS];
    endfunction

    function automatic logic [DATA_BITS-1:0] cnt_byte(input logic [COUNT_BITS-1:0] c,
                                                      input logic [IDX_W-1:0] i);
        logic [COUNT_BITS-1:0] s;
        s = c << (i * DATA_BITS);
        return s[COUNT_BITS-1 -: DATA_BITS];
    endfunction

    always_comb begin
        state_d   = state_q;
        ph_d      = ph_q;
        idx_d     = idx_q;
        words_d   = words_q;
        count_d   = count_q;
        shreg_d   = shreg_q;
        tx_en_d   = 1'b0;
        tx_data_d = tx_data_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
`ifdef RESP_STREAM_CHECKSUM_EN
        csum_d    = csum_q;
`endif
        iss       = 1'b0;
        iss_state = state_q;
        iss_idx   = idx_q;
        iss_word  = shreg_q;
        iss_byte  = '0;
        field_end = 1'b0;
        finish    = 1'b0;

        if (abort) begin
            state_d = S_IDLE;
            ph_d    = PH_FREE;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (start) begin
                    words_d = word_count;
                    count_d = word_count;
`ifdef RESP_STREAM_CHECKSUM_EN
                    csum_d  = '0;
`endif
                    busy_d  = 1'b1;
                    idx_d   = '0;
                    state_d = S_HDR;
                    ph_d    = PH_FREE;
                    if (!tx_busy) begin
                        iss       = 1'b1;
                        iss_state = S_HDR;
                        iss_idx   = '0;
                    end
                end
                S_FETCH: if (!fifo_empty) begin
                    state_d = S_LATCH;
                    if (words_q != '0) words_d = words_q - 1'b1;
                end
                // Issue the first byte straight from the FIFO output so LATCH costs no extra cycle.
                S_LATCH: begin
                    shreg_d = fifo_dout;
                    state_d = S_SEND;
                    idx_d   = '0;
                    ph_d    = PH_FREE;
                    if (!tx_busy) begin
                        iss       = 1'b1;
                        iss_state = S_SEND;
                        iss_idx   = '0;
                        iss_word  = fifo_dout;
                    end
                end
                S_DONE: state_d = S_IDLE;
                default: begin
                    case (ph_q)
                        PH_FREE: if (!tx_busy) iss = 1'b1;
                        PH_ACK:  if (tx_busy) ph_d = PH_END;
                        default: if (!tx_busy) begin
                            case (state_q)
                                S_HDR: begin
                                    iss       = 1'b1;
                                    iss_state = S_CNT;
                                    iss_idx   = '0;
                                end
                                S_CNT: if (idx_q == CNT_LAST) field_end = 1'b1;
                                       else begin
                                           iss     = 1'b1;
                                           iss_idx = idx_q + 1'b1;
                                       end
                                S_SEND: if (idx_q == WORD_LAST) field_end = 1'b1;
                                        else begin
                                            iss     = 1'b1;
                                            iss_idx = idx_q + 1'b1;
                                        end
                                default: finish = 1'b1;
                            endcase
                            if (field_end) begin
                                if (words_q != '0) state_d = S_FETCH;
                                else begin
`ifdef RESP_STREAM_CHECKSUM_EN
                                    iss       = 1'b1;
                                    iss_state = S_CSUM;
                                    iss_idx   = '0;
`else
                                    finish = 1'b1;
`endif
                                end
                            end
                            if (finish) begin
                                state_d = S_DONE;
                                done_d  = 1'b1;
                                busy_d  = 1'b0;
                            end
                        end
                    endcase
                end
            endcase

            if (iss) begin
                case (iss_state)
                    S_HDR:  iss_byte = RESPONSE_ID;
                    S_CNT:  iss_byte = cnt_byte(count_q, iss_idx);
                    S_SEND: iss_byte = word_byte(iss_word, iss_idx);
`ifdef RESP_STREAM_CHECKSUM_EN
                    S_CSUM: iss_byte = csum_q;
`endif
                    default: iss_byte = '0;
                endcase
                state_d   = iss_state;
                idx_d     = iss_idx;
                ph_d      = PH_ACK;
                tx_en_d   = 1'b1;
                tx_data_d = iss_byte;
`ifdef RESP_STREAM_CHECKSUM_EN
                if (iss_state == S_CNT || iss_state == S_SEND) csum_d = csum_d ^ iss_byte;
`endif
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            ph_q      <= PH_FREE;
            idx_q     <= '0;
            words_q   <= '0;
            count_q   <= '0;
            shreg_q   <= '0;
            tx_en_q   <= 1'b0;
            tx_data_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef RESP_STREAM_CHECKSUM_EN
            csum_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            ph_q      <= ph_d;
            idx_q     <= idx_d;
            words_q   <= words_d;
            count_q   <= count_d;
            shreg_q   <= shreg_d;
            tx_en_q   <= tx_en_d;
            tx_data_q <= tx_data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef RESP_STREAM_CHECKSUM_EN
            csum_q    <= csum_d;
`endif
        end
    end

    assign fifo_rd_en = (state_q == S_FETCH) && !fifo_empty && !abort;
    assign stall      = (state_q == S_FETCH) && fifo_empty;
    assign tx_enable  = tx_en_q;
    assign tx_data    = tx_data_q;
    assign busy       = busy_q;
    assign done       = done_q;
endmodule

// File: tb/tb_resp_stream_ctrl.sv
// Bench for resp_stream_ctrl: FIFO and 10-cycle UART models, frame-level byte scoreboard.
module tb_resp_stream_ctrl;
    logic        clk = 1'b0, reset = 1'b1, start = 1'b0, abort = 1'b0;
    logic [15:0] word_count = '0;
    logic        fifo_empty, fifo_rd_en;
    logic [31:0] fifo_dout = '0;
    logic        tx_busy, tx_enable, busy, done, stall;
    logic [7:0]  tx_data;

    logic [31:0] mem [0:63];
    int          wr_ptr = 0, rd_ptr = 0, busy_cnt = 0;
    logic        force_busy = 1'b0;
    logic [7:0]  exp_q[$];
    logic [7:0]  sent_q[$];
    int          n_tests = 0, n_fail = 0, n_rd = 0, n_done = 0;
    logic        ack_seen = 1'b1;

    resp_stream_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .word_count(word_count),
        .fifo_empty(fifo_empty), .fifo_dout(fifo_dout), .fifo_rd_en(fifo_rd_en),
        .tx_busy(tx_busy), .tx_enable(tx_enable), .tx_data(tx_data),
        .busy(busy), .done(done), .stall(stall)
    );

    always #5 clk = ~clk;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign tx_busy    = force_busy || (busy_cnt != 0);

    always @(posedge clk) begin
        if (fifo_rd_en && rd_ptr != wr_ptr) begin
            fifo_dout <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    always @(posedge clk) begin
        if (tx_enable) busy_cnt <= 10;
        else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] pack(input logic [7:0] q[$]);
        logic [127:0] v = '0;
        foreach (q[i]) v = {v[119:0], q[i]};
        return v;
    endfunction

    task automatic chk_sent(input string name, input int n, input logic [127:0] lit);
        chk({name, "_len"}, sent_q.size(), n);
        chk(name, pack(sent_q), lit);
    endtask

    // Frame model: header, count MSB first, each word MSB first, optional XOR byte.
    task automatic build_frame(input int wc, input logic [31:0] w0, input logic [31:0] w1);
        logic [7:0]  x;
        logic [31:0] w;
        exp_q.delete();
        sent_q.delete();
        exp_q.push_back(8'hAB);
        exp_q.push_back(wc[15:8]);
        exp_q.push_back(wc[7:0]);
        x = wc[15:8] ^ wc[7:0];
        for (int k = 0; k < wc; k++) begin
            w = (k == 0) ? w0 : w1;
            for (int b = 3; b >= 0; b--) begin
                exp_q.push_back(w[8*b +: 8]);
                x = x ^ w[8*b +: 8];
            end
        end
`ifdef RESP_STREAM_CHECKSUM_EN
        exp_q.push_back(x);
`endif
    endtask

    task automatic push(input logic [31:0] w);
        mem[wr_ptr] = w;
        wr_ptr++;
    endtask

    task automatic pulse_start(input logic [15:0] wc);
        word_count = wc;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int bound);
        int d0 = n_done;
        int i = 0;
        while (n_done == d0 && i < bound) begin
            @(posedge clk); #1;
            i++;
        end
        chk(name, n_done != d0, 1'b1);
    endtask

    task automatic wait_sent(input int n, input int bound);
        int i = 0;
        while (sent_q.size() < n && i < bound) begin
            @(posedge clk); #1;
            i++;
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (fifo_rd_en) begin
                n_rd++;
                chk("rd_when_empty", fifo_empty, 1'b0);
            end
            if (done) begin
                n_done++;
                chk("done_busy_low", busy, 1'b0);
                chk("done_all_sent", exp_q.size(), 0);
            end
            if (tx_enable) begin
                chk("en_while_busy", tx_busy, 1'b0);
                chk("en_after_ack", ack_seen, 1'b1);
                ack_seen = 1'b0;
                sent_q.push_back(tx_data);
                chk("byte_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) chk("tx_byte", tx_data, exp_q.pop_front());
            end
            if (tx_busy) ack_seen = 1'b1;
        end
    end

    initial begin
        #2000000;
        n_fail++;
        $display("FAIL watchdog: got timeout, want finish");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int rd0, dn0;
        logic stall_ok;

        #12;
        chk("rst_outputs", {tx_enable, fifo_rd_en, busy, done, stall, tx_data}, '0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Two words; a second start mid-frame must be ignored.
        push(32'h11223344);
        push(32'hA0B0C0D0);
        build_frame(2, 32'h11223344, 32'hA0B0C0D0);
        chk("model_t1", pack(exp_q), 88'hAB_00_02_11_22_33_44_A0_B0_C0_D0);
        rd0 = n_rd; dn0 = n_done;
        pulse_start(16'd2);
        chk("hdr_latency", tx_enable, 1'b1);
        chk("busy_on_start", busy, 1'b1);
        repeat (30) @(posedge clk);
        #1;
        pulse_start(16'd5);
        wait_done("t1_done", 3000);
        repeat (5) @(posedge clk);
        #1;
        chk("t1_rd_count", n_rd - rd0, 2);
        chk("t1_done_count", n_done - dn0, 1);
        chk("t1_idle", busy, 1'b0);
        chk_sent("t1_bytes", 11, 88'hAB_00_02_11_22_33_44_A0_B0_C0_D0);

        // Zero words: header and count only.
        build_frame(0, '0, '0);
        rd0 = n_rd;
        pulse_start(16'd0);
        wait_done("t2_done", 2000);
        chk("t2_rd_count", n_rd - rd0, 0);
        chk_sent("t2_bytes", 3, 24'hAB_00_00);

        // Empty FIFO stalls the frame until a word arrives.
        build_frame(1, 32'hDEADBEEF, '0);
        pulse_start(16'd1);
        wait_sent(3, 1000);
        begin
            int i = 0;
            while (!stall && i < 200) begin
                @(posedge clk); #1;
                i++;
            end
        end
        chk("t3_stall_seen", stall, 1'b1);
        stall_ok = 1'b1;
        rd0 = n_rd;
        repeat (50) begin
            @(posedge clk); #1;
            if (!stall) stall_ok = 1'b0;
        end
        chk("t3_stall_held", stall_ok, 1'b1);
        chk("t3_no_rd", n_rd - rd0, 0);
        push(32'hDEADBEEF);
        @(posedge clk); #1;
        chk("t3_stall_clear", stall, 1'b0);
        wait_done("t3_done", 2000);
        chk("t3_rd_count", n_rd - rd0, 1);
        chk_sent("t3_bytes", 7, 56'hAB_00_01_DE_AD_BE_EF);

        // Abort after byte 0x22, then a fresh frame.
        push(32'h11223344);
        push(32'hA0B0C0D0);
        build_frame(2, 32'h11223344, 32'hA0B0C0D0);
        dn0 = n_done;
        pulse_start(16'd2);
        wait_sent(5, 1000);
        chk("t4_reached", sent_q.size(), 5);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("t4_busy_drop", busy, 1'b0);
        chk("t4_stall_drop", stall, 1'b0);
        exp_q.delete();
        repeat (100) @(posedge clk);
        #1;
        chk("t4_no_more_bytes", sent_q.size(), 5);
        chk("t4_last", sent_q[4], 8'h22);
        chk("t4_no_done", n_done - dn0, 0);
        wr_ptr = rd_ptr;
        push(32'h55667788);
        build_frame(1, 32'h55667788, '0);
        pulse_start(16'd1);
        wait_done("t4_restart_done", 2000);
        chk_sent("t4_restart", 7, 56'hAB_00_01_55_66_77_88);

        // Asynchronous reset mid-frame.
        push(32'h11223344);
        push(32'hA0B0C0D0);
        build_frame(2, 32'h11223344, 32'hA0B0C0D0);
        pulse_start(16'd2);
        wait_sent(3, 1000);
        @(negedge clk); #2;
        reset = 1'b1;
        #1;
        chk("t5_async_reset", {tx_enable, fifo_rd_en, busy, done, stall, tx_data}, '0);
        @(posedge clk); #1;
        reset = 1'b0;
        exp_q.delete();
        wr_ptr = rd_ptr;
        repeat (20) @(posedge clk);
        #1;

        // UART busy at start: header waits for it.
        build_frame(0, '0, '0);
        force_busy = 1'b1;
        pulse_start(16'd0);
        repeat (20) @(posedge clk);
        #1;
        chk("t6_held", sent_q.size(), 0);
        chk("t6_busy", busy, 1'b1);
        force_busy = 1'b0;
        wait_done("t6_done", 2000);
        chk_sent("t6_bytes", 3, 24'hAB_00_00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
